spu_wb_regfile: RTL

- Consumer end of the MEM/WB pipeline register: the writeback stage plus the 128-entry x 128-bit SPU register file.
- Selects the writeback value from load data or ALU result and writes it to register RT.
- Provides three registered read ports (RA, RB, RC) with same-cycle write bypass.
- Keeps a per-register busy scoreboard so the issue stage stalls on RAW/WAW hazards until the producing result has been written back.

---
 rtl/spu_wb_regfile.sv | 107 ++++++++++
 1 files changed

// File: rtl/spu_wb_regfile.sv
// SPU writeback stage and 128 x 128-bit register file.
// Selects the writeback value, writes it to RT, serves three registered
// read ports with write-first bypass, and tracks a per-register busy
// scoreboard that stalls issue on RAW/WAW hazards.
//
// Handshake: this block has no ready/valid back-pressure on writeback.
// wb_valid is a qualifier that is always accepted. On the issue side,
// an issue (issue_valid) is accepted only in a cycle where stall is 0.
// Operand reads (rd_en) are always performed; the issue stage discards
// them while stall is high.
module spu_wb_regfile #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic              wb_mem_to_reg,
  input  logic [DATA_W-1:0] wb_read_data,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [ADDR_W-1:0] wb_rt,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic [ADDR_W-1:0] rc_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] rc_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rt,
  output logic              stall
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;
  logic [DATA_W-1:0] ra_q, ra_d;
  logic [DATA_W-1:0] rb_q, rb_d;
  logic [DATA_W-1:0] rc_q, rc_d;

  logic [DATA_W-1:0] wb_val;
  logic [NREGS-1:0]  clearing;
  logic [NREGS-1:0]  eff_busy;

  assign ra_data = ra_q;
  assign rb_data = rb_q;
  assign rc_data = rc_q;

  // Writeback value select and the scoreboard view that already sees
  // this cycle's writeback as complete.
  always_comb begin
    wb_val   = wb_mem_to_reg ? wb_read_data : wb_alu_result;
    clearing = '0;
    if (wb_valid) clearing[wb_rt] = 1'b1;
    eff_busy = busy_q & ~clearing;
  end

  // Hazard stall: any busy source operand, or a busy destination (WAW).
  always_comb begin
    stall = ~reset & ((rd_en & (eff_busy[ra_addr] | eff_busy[rb_addr] |
                                eff_busy[rc_addr])) |
                      (issue_valid & eff_busy[issue_rt]));
  end

  // Next-state for register array and busy bits; set after clear so a
  // new producer on the same index overrides the retiring one.
  always_comb begin
    regs_d = regs_q;
    if (wb_valid) regs_d[wb_rt] = wb_val;
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_rt] = 1'b0;
    if (issue_valid && !stall) busy_d[issue_rt] = 1'b1;
  end

  // Read ports with write-first bypass; hold when rd_en is low.
  always_comb begin
    ra_d = ra_q;
    rb_d = rb_q;
    rc_d = rc_q;
    if (rd_en) begin
      ra_d = (wb_valid && wb_rt == ra_addr) ? wb_val : regs_q[ra_addr];
      rb_d = (wb_valid && wb_rt == rb_addr) ? wb_val : regs_q[rb_addr];
      rc_d = (wb_valid && wb_rt == rc_addr) ? wb_val : regs_q[rc_addr];
    end
  end

  // State registers with synchronous reset to all-zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      rc_q   <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      ra_q   <= ra_d;
      rb_q   <= rb_d;
      rc_q   <= rc_d;
    end
  end

endmodule
